// File: rtl/noncoh_acc_ctrl.sv
// Sequencer for the noncoherent accumulation datapath: sweeps coherent results and ping-pong
// noncoherent amplitudes through noncoh_sum, retrying once with extra_shift on overflow.
module noncoh_acc_ctrl #(
  parameter int unsigned AW    = 10,
  parameter int unsigned EXP_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             first_pass,
  input  logic [AW-1:0]    cfg_len,
  input  logic [3:0]       cfg_coh_shift,
  input  logic [3:0]       cfg_noncoh_shift,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] nc_exp,
  output logic             nc_bank,
  output logic             coh_rd_en,
  output logic [AW-1:0]    coh_rd_addr,
  input  logic [23:0]      coh_rd_data,
  output logic             nc_rd_en,
  output logic [AW:0]      nc_rd_addr,
  input  logic [7:0]       nc_rd_data,
  output logic             nc_wr_en,
  output logic [AW:0]      nc_wr_addr,
  output logic [7:0]       nc_wr_data,
  output logic             coh_valid,
  output logic [23:0]      coh_data,
  output logic [3:0]       coh_shift,
  output logic [7:0]       noncoh_data,
  output logic [3:0]       noncoh_shift,
  output logic             extra_shift,
  input  logic             exceed,
  input  logic [8:0]       noncoh_out
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCheck, StDone} state_e;

  state_e           state_q;
  logic             first_q;
  logic [AW-1:0]    len_q;
  logic [3:0]       coh_shift_q;
  logic [3:0]       noncoh_shift_q;
  logic             src_q;
  logic             extra_q;
  logic             ovf_q;
  logic [AW-1:0]    k_q;
  logic [1:0]       drain_q;
  logic [3:0]       vld_q;
  logic [AW-1:0]    idx_q [4];
  logic             nc_bank_q;
  logic [EXP_W-1:0] nc_exp_q;
  logic [EXP_W:0]   exp_sum;
  logic [EXP_W-1:0] exp_next;

  always_comb begin
    exp_sum  = {1'b0, (first_q ? {EXP_W{1'b0}} : nc_exp_q)} + {{EXP_W{1'b0}}, extra_q};
    exp_next = exp_sum[EXP_W] ? {EXP_W{1'b1}} : exp_sum[EXP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= StIdle;
      first_q        <= 1'b0;
      len_q          <= '0;
      coh_shift_q    <= '0;
      noncoh_shift_q <= '0;
      src_q          <= 1'b0;
      extra_q        <= 1'b0;
      ovf_q          <= 1'b0;
      k_q            <= '0;
      drain_q        <= '0;
      vld_q          <= '0;
      for (int i = 0; i < 4; i++) idx_q[i] <= '0;
      nc_bank_q      <= 1'b0;
      nc_exp_q       <= '0;
    end else begin
      // Stage i of the pipe corresponds to cycle T+k+i+1 of an index issued at T+k.
      vld_q    <= {vld_q[2:0], state_q == StIssue};
      idx_q[0] <= k_q;
      idx_q[1] <= idx_q[0];
      idx_q[2] <= idx_q[1];
      idx_q[3] <= idx_q[2];
      if (vld_q[2] && exceed && !extra_q) ovf_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            first_q        <= first_pass;
            len_q          <= cfg_len;
            coh_shift_q    <= cfg_coh_shift;
            noncoh_shift_q <= first_pass ? 4'd0 : cfg_noncoh_shift;
            src_q          <= nc_bank_q;
            extra_q        <= 1'b0;
            ovf_q          <= 1'b0;
            k_q            <= '0;
            state_q        <= (cfg_len == '0) ? StCheck : StIssue;
          end
        end
        StIssue: begin
          if (k_q == len_q - 1'b1) begin
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == 2'd3) state_q <= StCheck;
          else drain_q <= drain_q + 1'b1;
        end
        StCheck: begin
          if (ovf_q && !extra_q) begin
            extra_q <= 1'b1;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            state_q <= StIssue;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          nc_bank_q <= ~src_q;
          nc_exp_q  <= exp_next;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign nc_exp       = nc_exp_q;
  assign nc_bank      = nc_bank_q;
  assign coh_rd_en    = (state_q == StIssue);
  assign coh_rd_addr  = coh_rd_en ? k_q : '0;
  assign coh_valid    = vld_q[0];
  assign coh_data     = vld_q[0] ? coh_rd_data : '0;
  assign nc_rd_en     = vld_q[1] && !first_q;
  assign nc_rd_addr   = nc_rd_en ? {src_q, idx_q[1]} : '0;
  assign noncoh_data  = (vld_q[2] && !first_q) ? nc_rd_data : '0;
  assign nc_wr_en     = vld_q[3];
  assign nc_wr_addr   = vld_q[3] ? {~src_q, idx_q[3]} : '0;
  assign nc_wr_data   = !vld_q[3] ? 8'd0 : (noncoh_out[8] ? 8'd255 : noncoh_out[7:0]);
  assign coh_shift    = coh_shift_q;
  assign noncoh_shift = noncoh_shift_q;
  assign extra_shift  = extra_q;

endmodule

// File: tb/tb_noncoh_acc_ctrl.sv
// Directed bench for noncoh_acc_ctrl with coherent buffer, ping-pong RAM and a toy noncoh_sum.
module tb_noncoh_acc_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned EXP_W = 4;

  logic             clk, rst_b, start, first_pass;
  logic [AW-1:0]    cfg_len;
  logic [3:0]       cfg_coh_shift, cfg_noncoh_shift;
  logic             busy, done, nc_bank;
  logic [EXP_W-1:0] nc_exp;
  logic             coh_rd_en, nc_rd_en, nc_wr_en, coh_valid, extra_shift, exceed;
  logic [AW-1:0]    coh_rd_addr;
  logic [23:0]      coh_rd_data, coh_data;
  logic [AW:0]      nc_rd_addr, nc_wr_addr;
  logic [7:0]       nc_rd_data, nc_wr_data, noncoh_data;
  logic [3:0]       coh_shift, noncoh_shift;
  logic [8:0]       noncoh_out;

  noncoh_acc_ctrl #(.AW(AW), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .first_pass(first_pass), .cfg_len(cfg_len),
    .cfg_coh_shift(cfg_coh_shift), .cfg_noncoh_shift(cfg_noncoh_shift), .busy(busy),
    .done(done), .nc_exp(nc_exp), .nc_bank(nc_bank), .coh_rd_en(coh_rd_en),
    .coh_rd_addr(coh_rd_addr), .coh_rd_data(coh_rd_data), .nc_rd_en(nc_rd_en),
    .nc_rd_addr(nc_rd_addr), .nc_rd_data(nc_rd_data), .nc_wr_en(nc_wr_en),
    .nc_wr_addr(nc_wr_addr), .nc_wr_data(nc_wr_data), .coh_valid(coh_valid),
    .coh_data(coh_data), .coh_shift(coh_shift), .noncoh_data(noncoh_data),
    .noncoh_shift(noncoh_shift), .extra_shift(extra_shift), .exceed(exceed),
    .noncoh_out(noncoh_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] coh_mem [16];
  logic [7:0]  nc_ram  [32];
  logic [8:0]  cd1, cd2;
  logic        vd1, vd2;
  logic [9:0]  sum;

  always @(posedge clk) begin
    if (coh_rd_en) coh_rd_data <= coh_mem[coh_rd_addr];
    if (nc_rd_en)  nc_rd_data  <= nc_ram[nc_rd_addr];
    if (nc_wr_en)  nc_ram[nc_wr_addr] <= nc_wr_data;
  end

  // Toy accumulator: exceed is combinational on the noncoh slot, result registered one cycle later.
  assign sum    = ({1'b0, cd2} >> extra_shift) + {2'b00, noncoh_data};
  assign exceed = vd2 && (sum >= 10'd256);
  always @(posedge clk) begin
    vd1        <= coh_valid;
    cd1        <= coh_data[8:0];
    vd2        <= vd1;
    cd2        <= cd1;
    noncoh_out <= (sum > 10'd511) ? 9'h1FF : sum[8:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   s_cyc, done_cyc, done_cnt, coh_cnt, rd_cnt, wr_cnt, first_wr_cyc, seq_bad, nd_bad, nd_idx;
  logic seq_chk, nd_chk, src_exp;
  int   nd_exp [4];
  int   n_chk = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (coh_rd_en) begin
      coh_cnt++;
      if (seq_chk && coh_rd_addr != AW'(cyc - s_cyc - 1)) seq_bad++;
    end
    if (nc_rd_en) begin
      rd_cnt++;
      if (seq_chk && nc_rd_addr != {src_exp, AW'(cyc - s_cyc - 3)}) seq_bad++;
    end
    if (nc_wr_en) begin
      if (wr_cnt == 0) first_wr_cyc = cyc;
      wr_cnt++;
      if (seq_chk && nc_wr_addr != {~src_exp, AW'(cyc - s_cyc - 5)}) seq_bad++;
    end
    if (nd_chk && vd2) begin
      if (nd_idx < 4 && int'(noncoh_data) != nd_exp[nd_idx]) nd_bad++;
      nd_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0; coh_cnt = 0; rd_cnt = 0; wr_cnt = 0; first_wr_cyc = -1;
    seq_bad = 0; nd_bad = 0; nd_idx = 0; done_cyc = -1;
  endtask

  task automatic load_coh(input int a, input int b, input int c, input int d);
    coh_mem[0] = 24'(a); coh_mem[1] = 24'(b); coh_mem[2] = 24'(c); coh_mem[3] = 24'(d);
  endtask

  task automatic launch(input logic fp, input int len, input logic [3:0] cs, input logic [3:0] ns);
    @(negedge clk);
    first_pass = fp; cfg_len = AW'(len); cfg_coh_shift = cs; cfg_noncoh_shift = ns;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; first_pass = 1'b0; cfg_len = '0;
    cfg_coh_shift = '0; cfg_noncoh_shift = '0; seq_chk = 1'b0; nd_chk = 1'b0; src_exp = 1'b0;
    for (int i = 0; i < 16; i++) coh_mem[i] = '0;
    for (int i = 0; i < 32; i++) nc_ram[i] = '0;
    clear_stats();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_coh_rd_en", 32'(coh_rd_en), 0);
    check("rst_nc_wr_en", 32'(nc_wr_en), 0);
    check("rst_nc_bank", 32'(nc_bank), 0);
    check("rst_nc_exp", 32'(nc_exp), 0);
    rst_b = 1'b1;

    // First pass, no previous data: results land in bank 1 unchanged.
    load_coh(10, 20, 30, 40);
    clear_stats(); seq_chk = 1'b1; src_exp = 1'b0;
    launch(1'b1, 4, 4'd3, 4'd5);
    check("t1_busy", 32'(busy), 1);
    check("t1_coh_shift", 32'(coh_shift), 3);
    check("t1_noncoh_shift", 32'(noncoh_shift), 0);
    wait_done("t1", 40);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_done_lat", 32'(done_cyc - s_cyc), 10);
    check("t1_coh_reads", 32'(coh_cnt), 4);
    check("t1_nc_reads", 32'(rd_cnt), 0);
    check("t1_writes", 32'(wr_cnt), 4);
    check("t1_first_wr_lat", 32'(first_wr_cyc - s_cyc), 5);
    check("t1_seq", 32'(seq_bad), 0);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_nc_bank", 32'(nc_bank), 1);
    check("t1_nc_exp", 32'(nc_exp), 0);
    check("t1_ram0", 32'(nc_ram[16]), 10);
    check("t1_ram1", 32'(nc_ram[17]), 20);
    check("t1_ram2", 32'(nc_ram[18]), 30);
    check("t1_ram3", 32'(nc_ram[19]), 40);

    // Second pass: read bank 1, accumulate, write bank 0.
    load_coh(1, 2, 3, 4);
    nd_exp = '{10, 20, 30, 40};
    clear_stats(); seq_chk = 1'b1; nd_chk = 1'b1; src_exp = 1'b1;
    launch(1'b0, 4, 4'd2, 4'd6);
    check("t2_noncoh_shift", 32'(noncoh_shift), 6);
    wait_done("t2", 40);
    check("t2_nc_reads", 32'(rd_cnt), 4);
    check("t2_writes", 32'(wr_cnt), 4);
    check("t2_seq", 32'(seq_bad), 0);
    check("t2_noncoh_data", 32'(nd_bad), 0);
    check("t2_noncoh_slots", 32'(nd_idx), 4);
    check("t2_ram0", 32'(nc_ram[0]), 11);
    check("t2_ram1", 32'(nc_ram[1]), 22);
    check("t2_ram2", 32'(nc_ram[2]), 33);
    check("t2_ram3", 32'(nc_ram[3]), 44);
    check("t2_nc_bank", 32'(nc_bank), 0);
    check("t2_nc_exp", 32'(nc_exp), 0);
    seq_chk = 1'b0; nd_chk = 1'b0;

    // Overflow on index 2, retry with extra_shift clears it.
    load_coh(5, 5, 250, 5);
    clear_stats();
    launch(1'b0, 4, 4'd0, 4'd0);
    wait_done("t3", 60);
    check("t3_done_cnt", 32'(done_cnt), 1);
    check("t3_done_lat", 32'(done_cyc - s_cyc), 19);
    check("t3_coh_reads", 32'(coh_cnt), 8);
    check("t3_writes", 32'(wr_cnt), 8);
    check("t3_ram0", 32'(nc_ram[16]), 13);
    check("t3_ram1", 32'(nc_ram[17]), 24);
    check("t3_ram2", 32'(nc_ram[18]), 158);
    check("t3_ram3", 32'(nc_ram[19]), 46);
    check("t3_nc_bank", 32'(nc_bank), 1);
    check("t3_nc_exp", 32'(nc_exp), 1);

    // Overflow persists on the retry: saturating write, no second retry.
    load_coh(0, 0, 400, 0);
    clear_stats();
    launch(1'b0, 4, 4'd0, 4'd0);
    wait_done("t4", 60);
    repeat (10) @(negedge clk);
    check("t4_done_cnt", 32'(done_cnt), 1);
    check("t4_coh_reads", 32'(coh_cnt), 8);
    check("t4_ram0", 32'(nc_ram[0]), 13);
    check("t4_ram2", 32'(nc_ram[2]), 255);
    check("t4_ram3", 32'(nc_ram[3]), 46);
    check("t4_nc_bank", 32'(nc_bank), 0);
    check("t4_nc_exp", 32'(nc_exp), 2);

    // Zero-length pass: done with no accesses, bank toggles, exponent kept.
    clear_stats();
    launch(1'b0, 0, 4'd0, 4'd0);
    wait_done("t5", 10);
    check("t5_done_lat", 32'(done_cyc - s_cyc), 2);
    check("t5_accesses", 32'(coh_cnt + rd_cnt + wr_cnt), 0);
    check("t5_nc_bank", 32'(nc_bank), 1);
    check("t5_nc_exp", 32'(nc_exp), 2);

    // Start while busy is ignored.
    load_coh(0, 0, 0, 0);
    clear_stats();
    launch(1'b0, 4, 4'd0, 4'd0);
    @(negedge clk);
    first_pass = 1'b1; cfg_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", 40);
    repeat (15) @(negedge clk);
    check("t6_done_cnt", 32'(done_cnt), 1);
    check("t6_coh_reads", 32'(coh_cnt), 4);
    check("t6_ram2", 32'(nc_ram[2]), 158);
    check("t6_nc_bank", 32'(nc_bank), 0);
    check("t6_nc_exp", 32'(nc_exp), 2);

    // Asynchronous reset mid-issue, then a fresh pass.
    load_coh(7, 8, 0, 0);
    clear_stats();
    launch(1'b1, 4, 4'd1, 4'd1);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 0);
    check("t7_coh_rd_en", 32'(coh_rd_en), 0);
    check("t7_coh_valid", 32'(coh_valid), 0);
    check("t7_coh_shift", 32'(coh_shift), 0);
    check("t7_nc_bank", 32'(nc_bank), 0);
    check("t7_nc_exp", 32'(nc_exp), 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (10) @(negedge clk);
    check("t7_no_done", 32'(done_cnt), 0);
    clear_stats();
    launch(1'b1, 2, 4'd0, 4'd0);
    wait_done("t7", 30);
    check("t7_done_lat", 32'(done_cyc - s_cyc), 8);
    check("t7_ram0", 32'(nc_ram[16]), 7);
    check("t7_ram1", 32'(nc_ram[17]), 8);
    check("t7_nc_bank", 32'(nc_bank), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
